// File: rtl/fht_io_ctrl.sv
// Frame sequencer for fht_top: scatters one frame of ADC samples into the four
// RAM banks, kicks the core, waits for it with a timeout, then drains the
// transformed frame in natural index order over a valid/ready result stream.
module fht_io_ctrl #(
    parameter int unsigned D_BIT     = 16,
    parameter int unsigned A_BIT     = 8,
    parameter int unsigned BITREV_IN = 0,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned TO_BIT    = 20
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iEN,
    input  logic                 iADC_VALID,
    input  logic [D_BIT-1:0]     iADC_DATA,
    output logic                 oADC_READY,
    output logic                 oFHT_START,
    input  logic                 iFHT_RDY,
    output logic [3:0]           oFHT_WE,
    output logic [D_BIT-1:0]     oFHT_DATA,
    output logic [A_BIT-1:0]     oFHT_ADDR_WR,
    output logic [A_BIT-1:0]     oFHT_ADDR_RD,
    input  logic [D_BIT-1:0]     iFHT_DATA_0,
    input  logic [D_BIT-1:0]     iFHT_DATA_1,
    input  logic [D_BIT-1:0]     iFHT_DATA_2,
    input  logic [D_BIT-1:0]     iFHT_DATA_3,
    output logic                 oRES_VALID,
    output logic [D_BIT-1:0]     oRES_DATA,
    output logic [A_BIT+1:0]     oRES_INDEX,
    input  logic                 iRES_READY,
    output logic                 oBUSY,
    output logic                 oFRAME_DONE,
    output logic                 oERR
);

    localparam int unsigned N_BIT = A_BIT + 2;
    localparam logic [N_BIT-1:0]  N_LAST   = '1;
    // Terminal count minus one: the abort fires as the counter reaches all-ones.
    localparam logic [TO_BIT-1:0] TO_PRE   = {{(TO_BIT-1){1'b1}}, 1'b0};
    localparam logic [1:0]        LAT_LAST = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StStart, StWaitBusy, StWaitRdy, StRdIssue, StRdWait, StRdOut
    } state_e;

    state_e              r_state, w_state_d;
    logic [N_BIT-1:0]    r_n, r_k;
    logic [TO_BIT-1:0]   r_to;
    logic [1:0]          r_lat;
    logic [3:0]          r_we;
    logic [D_BIT-1:0]    r_wdata, r_res_data;
    logic [A_BIT-1:0]    r_waddr;
    logic [N_BIT-1:0]    r_res_index;
    logic                r_start, r_done, r_err;

    logic                w_accept, w_res_acc, w_to_hit, w_lat_done, w_waiting;
    logic [N_BIT-1:0]    w_m;
    logic [D_BIT-1:0]    w_rd_data;

    function automatic logic [N_BIT-1:0] f_rev(input logic [N_BIT-1:0] v);
        for (int i = 0; i < int'(N_BIT); i++) begin
            f_rev[i] = v[N_BIT-1-i];
        end
    endfunction

    // Handshake qualifiers, bank-mapped write index and read-data bank select.
    always_comb begin
        w_accept   = (r_state == StLoad) && iADC_VALID;
        w_res_acc  = (r_state == StRdOut) && iRES_READY;
        w_waiting  = (r_state == StWaitBusy) || (r_state == StWaitRdy);
        w_to_hit   = w_waiting && (r_to == TO_PRE);
        w_lat_done = (r_lat == LAT_LAST);
        w_m        = (BITREV_IN != 0) ? f_rev(r_n) : r_n;
        w_rd_data  = iFHT_DATA_0;
        unique case (r_k[1:0])
            2'd0: w_rd_data = iFHT_DATA_0;
            2'd1: w_rd_data = iFHT_DATA_1;
            2'd2: w_rd_data = iFHT_DATA_2;
            2'd3: w_rd_data = iFHT_DATA_3;
        endcase
    end

    // Next-state decode.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:     if (iEN) w_state_d = StLoad;
            StLoad:     if (w_accept && (r_n == N_LAST)) w_state_d = StStart;
            StStart:    w_state_d = StWaitBusy;
            StWaitBusy: begin
                if (w_to_hit)       w_state_d = StIdle;
                else if (!iFHT_RDY) w_state_d = StWaitRdy;
            end
            StWaitRdy: begin
                if (w_to_hit)      w_state_d = StIdle;
                else if (iFHT_RDY) w_state_d = StRdIssue;
            end
            StRdIssue:  w_state_d = StRdWait;
            StRdWait:   if (w_lat_done) w_state_d = StRdOut;
            StRdOut: begin
                if (iRES_READY) w_state_d = (r_k == N_LAST) ? StIdle : StRdIssue;
            end
            default:    w_state_d = StIdle;
        endcase
    end

    // State register and datapath; pulses default low every cycle.
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            r_state     <= StIdle;
            r_n         <= '0;
            r_k         <= '0;
            r_to        <= '0;
            r_lat       <= '0;
            r_we        <= '0;
            r_wdata     <= '0;
            r_waddr     <= '0;
            r_start     <= 1'b0;
            r_res_data  <= '0;
            r_res_index <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_we    <= '0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            if ((r_state == StIdle) && iEN) r_n <= '0;
            if (w_accept) begin
                r_we    <= 4'b0001 << w_m[1:0];
                r_waddr <= w_m[N_BIT-1:2];
                r_wdata <= iADC_DATA;
                r_n     <= r_n + N_BIT'(1);
            end
            // START is registered so the pulse trails the final bank write by a cycle.
            if (r_state == StStart) begin
                r_start <= 1'b1;
                r_to    <= '0;
            end
            if (w_waiting) r_to <= r_to + TO_BIT'(1);
            if (w_to_hit) r_err <= 1'b1;
            if ((r_state == StWaitRdy) && (w_state_d == StRdIssue)) r_k <= '0;
            if (r_state == StRdIssue) r_lat <= '0;
            if (r_state == StRdWait) begin
                r_lat <= r_lat + 2'd1;
                if (w_lat_done) begin
                    r_res_data  <= w_rd_data;
                    r_res_index <= r_k;
                end
            end
            if (w_res_acc) begin
                r_k <= r_k + N_BIT'(1);
                if (r_k == N_LAST) r_done <= 1'b1;
            end
        end
    end

    assign oADC_READY   = (r_state == StLoad);
    assign oFHT_START   = r_start;
    assign oFHT_WE      = r_we;
    assign oFHT_DATA    = r_wdata;
    assign oFHT_ADDR_WR = r_waddr;
    // k only moves on a result accept, so the read address holds through RD_OUT.
    assign oFHT_ADDR_RD = r_k[N_BIT-1:2];
    assign oRES_VALID   = (r_state == StRdOut);
    assign oRES_DATA    = r_res_data;
    assign oRES_INDEX   = r_res_index;
    assign oBUSY        = (r_state != StIdle);
    assign oFRAME_DONE  = r_done;
    assign oERR         = r_err;

endmodule

// File: tb/tb_fht_io_ctrl.sv
// Bench for fht_io_ctrl with A_BIT=2: natural and bit-reversed write maps,
// behavioural fht_top (RDY low 40 cycles, oDATA_x = 100*x + addr, 2-cycle read),
// result stall, mid-frame reset and ready timeout.
module tb_fht_io_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, en, adc_valid, res_ready, stuck, to_phase;
    logic [15:0] adc_data;
    logic        m_rdy = 1'b1;
    int          m_cnt = 0;
    logic [1:0]  p1 = '0, p2 = '0;
    logic [15:0] fd0, fd1, fd2, fd3;

    logic        w0_ready, w0_start, w0_res_valid, w0_busy, w0_done, w0_err;
    logic [3:0]  w0_we, w0_res_index;
    logic [15:0] w0_wdata, w0_res_data;
    logic [1:0]  w0_waddr, w0_raddr;
    logic        w1_ready, w1_start, w1_res_valid, w1_busy, w1_done, w1_err;
    logic [3:0]  w1_we, w1_res_index;
    logic [15:0] w1_wdata, w1_res_data;
    logic [1:0]  w1_waddr, w1_raddr;

    typedef struct packed {logic [3:0] we; logic [1:0] addr; logic [15:0] data;} wr_t;
    typedef struct packed {logic [3:0] idx; logic [15:0] data;} rs_t;
    typedef struct packed {
        logic [15:0] din; logic [3:0] we; logic [1:0] addr; logic [3:0] we_r; logic [1:0] addr_r;
    } vec_t;

    localparam logic [63:0] WE_N   = 64'h8421_8421_8421_8421;
    localparam logic [63:0] ADDR_N = 64'h3333_2222_1111_0000;
    localparam logic [63:0] WE_R   = 64'h8888_2222_4444_1111;
    localparam logic [63:0] ADDR_R = 64'h3120_3120_3120_3120;

    vec_t vec[16];
    wr_t  wq0[$], wq1[$];
    rs_t  rq[$];
    int   n_chk = 0, n_fail = 0, cyc = 0, last_we_cyc = -10, n_start = 0, n_done = 0;
    logic start_prev = 1'b0, valid_in_to = 1'b0;

    fht_io_ctrl #(.D_BIT(16), .A_BIT(2), .BITREV_IN(0), .RD_LAT(2), .TO_BIT(6)) u_dut (
        .iCLK(clk), .iRESET(rst_n), .iEN(en), .iADC_VALID(adc_valid), .iADC_DATA(adc_data),
        .oADC_READY(w0_ready), .oFHT_START(w0_start), .iFHT_RDY(m_rdy), .oFHT_WE(w0_we),
        .oFHT_DATA(w0_wdata), .oFHT_ADDR_WR(w0_waddr), .oFHT_ADDR_RD(w0_raddr),
        .iFHT_DATA_0(fd0), .iFHT_DATA_1(fd1), .iFHT_DATA_2(fd2), .iFHT_DATA_3(fd3),
        .oRES_VALID(w0_res_valid), .oRES_DATA(w0_res_data), .oRES_INDEX(w0_res_index),
        .iRES_READY(res_ready), .oBUSY(w0_busy), .oFRAME_DONE(w0_done), .oERR(w0_err)
    );

    fht_io_ctrl #(.D_BIT(16), .A_BIT(2), .BITREV_IN(1), .RD_LAT(2), .TO_BIT(6)) u_dut_rev (
        .iCLK(clk), .iRESET(rst_n), .iEN(en), .iADC_VALID(adc_valid), .iADC_DATA(adc_data),
        .oADC_READY(w1_ready), .oFHT_START(w1_start), .iFHT_RDY(m_rdy), .oFHT_WE(w1_we),
        .oFHT_DATA(w1_wdata), .oFHT_ADDR_WR(w1_waddr), .oFHT_ADDR_RD(w1_raddr),
        .iFHT_DATA_0(fd0), .iFHT_DATA_1(fd1), .iFHT_DATA_2(fd2), .iFHT_DATA_3(fd3),
        .oRES_VALID(w1_res_valid), .oRES_DATA(w1_res_data), .oRES_INDEX(w1_res_index),
        .iRES_READY(res_ready), .oBUSY(w1_busy), .oFRAME_DONE(w1_done), .oERR(w1_err)
    );

    always #5 clk = ~clk;

    // Behavioural fht_top: RDY drops after start for 40 cycles; 2-cycle read pipeline.
    always @(posedge clk) begin
        p1 <= w0_raddr;
        p2 <= p1;
        if (w0_start) begin
            if (!stuck) begin
                m_rdy <= 1'b0;
                m_cnt <= 40;
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_rdy <= 1'b1;
        end
    end
    assign fd0 = 16'd0   + 16'(p2);
    assign fd1 = 16'd100 + 16'(p2);
    assign fd2 = 16'd200 + 16'(p2);
    assign fd3 = 16'd300 + 16'(p2);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Write scoreboards for both DUTs, start-pulse timing and pulse counters.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (w0_we != 4'd0) begin
            if (wq0.size() == 0) check("wr_nat_unexpected", {w0_we, w0_waddr}, 0);
            else begin
                e = wq0.pop_front();
                check("wr_nat", {w0_we, w0_waddr, w0_wdata}, {e.we, e.addr, e.data});
            end
        end
        if (w1_we != 4'd0) begin
            if (wq1.size() == 0) check("wr_rev_unexpected", {w1_we, w1_waddr}, 0);
            else begin
                e = wq1.pop_front();
                check("wr_rev", {w1_we, w1_waddr, w1_wdata}, {e.we, e.addr, e.data});
            end
        end
        if (w0_we == 4'b1000 && w0_waddr == 2'd3) last_we_cyc = cyc;
        if (w0_start) begin
            check("start_after_last_we", cyc, last_we_cyc + 1);
            check("start_single_cycle", start_prev, 0);
            n_start++;
        end
        start_prev = w0_start;
        if (w0_done) n_done++;
        if (to_phase && w0_res_valid) valid_in_to = 1'b1;
    end

    task automatic send(input int i);
        int t;
        wq0.push_back({vec[i].we, vec[i].addr, vec[i].din});
        wq1.push_back({vec[i].we_r, vec[i].addr_r, vec[i].din});
        adc_valid = 1'b1;
        adc_data  = vec[i].din;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!w0_ready && t < 50);
        if (!w0_ready) check("adc_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        adc_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {w0_busy, w0_ready, w0_start, w0_we, w0_waddr, w0_raddr, w0_res_valid,
                     w0_done, w0_err, w0_res_index}, 0);
        check({name, "_data"}, {w0_wdata, w0_res_data}, 0);
    endtask

    initial begin
        int t;
        int c;
        rs_t r;
        rst_n = 1'b0; en = 1'b0; adc_valid = 1'b0; adc_data = '0;
        res_ready = 1'b0; stuck = 1'b0; to_phase = 1'b0;
        for (int i = 0; i < 16; i++) begin
            vec[i].din    = 16'hA500 + 16'(i * 7);
            vec[i].we     = WE_N[i*4 +: 4];
            vec[i].addr   = ADDR_N[i*4 +: 2];
            vec[i].we_r   = WE_R[i*4 +: 4];
            vec[i].addr_r = ADDR_R[i*4 +: 2];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");

        // Partial frame, then reset while in LOAD.
        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b1;
        for (int i = 0; i < 6; i++) send(i);
        rst_n = 1'b0; en = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check_all_zero("midframe_reset");
        check("midframe_reset_queue", wq0.size() + wq1.size(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full frame with valid gaps; iEN dropped after the first sample.
        en = 1'b1;
        for (int k = 0; k < 16; k++) rq.push_back({4'(k), 16'(100 * (k % 4) + k / 4)});
        for (int i = 0; i < 16; i++) begin
            if (i % 5 == 2) repeat (2) begin @(posedge clk); #1; end
            send(i);
            if (i == 0) en = 1'b0;
        end
        for (int k = 0; k < 16; k++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!w0_res_valid && t < 200);
            if (!w0_res_valid) begin
                check("res_valid_timeout", 0, 1);
                break;
            end
            r = rq.pop_front();
            check("res_index", w0_res_index, r.idx);
            check("res_data", w0_res_data, r.data);
            check("res_addr_rd", w0_raddr, r.idx[3:2]);
            if (k == 3) begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_frozen", {w0_res_valid, w0_res_index, w0_res_data, w0_raddr},
                          {1'b1, r.idx, r.data, r.idx[3:2]});
                end
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            @(negedge clk);
            check("res_valid_drop", w0_res_valid, 0);
            if (k == 15) begin
                check("frame_done_pulse", w0_done, 1);
                check("idle_after_frame", w0_busy, 0);
            end
        end
        @(negedge clk);
        check("frame_done_count", n_done, 1);
        check("start_count", n_start, 1);

        // Core never drops RDY: the wait must time out into IDLE with oERR set.
        stuck = 1'b1; to_phase = 1'b1; en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(i);
            if (i == 0) en = 1'b0;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!w0_start && t < 20);
        check("timeout_start_seen", w0_start, 1);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!w0_err && c < 200);
        check("timeout_cycles", c, 63);
        check("idle_after_timeout", w0_busy, 0);
        repeat (3) @(negedge clk);
        check("err_sticky", w0_err, 1);
        check("no_result_on_timeout", valid_in_to, 0);
        check("done_count_after_timeout", n_done, 1);

        // A set error flag does not stop the next frame from starting.
        en = 1'b1;
        repeat (2) @(negedge clk);
        check("frame_after_err", w0_busy, 1);
        check("write_queues_drained", wq0.size() + wq1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
